// File: rtl/ray_wall_scan.sv
// Ray/wall scanner: tests one ray component against N_WALLS axis-aligned wall positions
// through a two-stage pipeline and reports the nearest hit distance and its wall index.
module ray_wall_scan #(
   parameter int N_WALLS    = 4,
   parameter int WALL_W     = 4,
   parameter int WALL_SHIFT = 6,
   parameter int DIR_W      = 10,
   parameter int ORI_W      = 10,
   parameter int DIST_W     = 19
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            in_valid,
   output logic                                            in_ready,
   input  logic [DIR_W-1:0]                                in_dir,
   input  logic [ORI_W-1:0]                                in_ori,
   input  logic [N_WALLS*WALL_W-1:0]                       in_walls,
   input  logic [N_WALLS-1:0]                              in_wall_en,
   output logic                                            out_valid,
   input  logic                                            out_ready,
   output logic [DIST_W-1:0]                               out_dist,
   output logic [((N_WALLS > 1) ? $clog2(N_WALLS) : 1)-1:0] out_idx,
   output logic                                            out_hit
);

   localparam int IDX_W  = (N_WALLS > 1) ? $clog2(N_WALLS) : 1;
   localparam int MAG_W  = DIR_W - 1;
   localparam int WP_W   = WALL_W + WALL_SHIFT;
   localparam int CMP_W  = ((ORI_W > WP_W) ? ORI_W : WP_W) + 2;
   localparam int PROD_W = CMP_W + MAG_W;
   localparam int SAT_W  = (PROD_W > DIST_W) ? PROD_W : DIST_W;
   localparam int INV_N  = 2 ** MAG_W;

   localparam logic [IDX_W-1:0] LAST     = IDX_W'(N_WALLS - 1);
   localparam logic [SAT_W-1:0] DIST_MAX = {{(SAT_W-DIST_W+1){1'b0}}, {(DIST_W-1){1'b1}}};

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   // Reciprocal of |dir|, rounded half up; 0 and 1 both map to the largest code.
   function automatic logic [MAG_W-1:0] inv_entry(input int k);
      if (k < 2) return {MAG_W{1'b1}};
      return MAG_W'(((1 << MAG_W) + k / 2) / k);
   endfunction

   logic [MAG_W-1:0] inv_rom [INV_N];
   for (genvar k = 0; k < INV_N; k++) begin : g_inv
      assign inv_rom[k] = inv_entry(k);
   end

   state_t                    state;
   logic [IDX_W-1:0]          cnt;
   logic [DIR_W-1:0]          dir_r;
   logic [ORI_W-1:0]          ori_r;
   logic [N_WALLS*WALL_W-1:0] walls_r;
   logic [N_WALLS-1:0]        en_r;

   logic                      s1_valid;
   logic [IDX_W-1:0]          s1_idx;
   logic                      s1_en;
   logic [MAG_W-1:0]          s1_mag;
   logic                      s1_sign;
   logic                      s1_less;
   logic [CMP_W-1:0]          s1_delta;
   logic [MAG_W-1:0]          s1_recip;

   logic [DIST_W-1:0]         best_dist;
   logic [IDX_W-1:0]          best_idx;
   logic                      best_hit;

   logic [DIR_W-1:0]          dir_abs;
   logic [MAG_W-1:0]          mag_c;
   logic [WALL_W-1:0]         wall_c;
   logic [WP_W-1:0]           wp_c;
   logic [CMP_W-1:0]          ori_x, wp_x, diff_c, delta_c;
   logic                      less_c;
   logic [PROD_W-1:0]         prod_c;
   logic [SAT_W-1:0]          prod_sh;
   logic [DIST_W-1:0]         dist_c;
   logic                      miss_c;

   // Stage 1 operands, all derived from the captured request.
   always_comb begin
      dir_abs = dir_r[DIR_W-1] ? (~dir_r + DIR_W'(1)) : dir_r;
      mag_c   = dir_abs[DIR_W-1] ? {MAG_W{1'b1}} : dir_abs[MAG_W-1:0];
      wall_c  = walls_r[int'(cnt)*WALL_W +: WALL_W];
      wp_c    = WP_W'(wall_c) << WALL_SHIFT;
      ori_x   = {{(CMP_W-ORI_W){ori_r[ORI_W-1]}}, ori_r};
      wp_x    = {{(CMP_W-WP_W){1'b0}}, wp_c};
      diff_c  = ori_x - wp_x;
      less_c  = $signed(wp_x) < $signed(ori_x);
      delta_c = diff_c[CMP_W-1] ? (~diff_c + CMP_W'(1)) : diff_c;
   end

   // Stage 2: a hit needs the wall to lie on the side the ray travels towards.
   always_comb begin
      prod_c  = PROD_W'(s1_delta) * PROD_W'(s1_recip);
      prod_sh = SAT_W'(prod_c >> 1);
      dist_c  = (prod_sh > DIST_MAX) ? DIST_MAX[DIST_W-1:0] : prod_sh[DIST_W-1:0];
      miss_c  = (s1_mag == '0) | (s1_sign ^ s1_less) | ~s1_en;
   end

   // NOTE: pure datapath registers carry no reset; they are only consumed when a valid flag says so.
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         dir_r   <= in_dir;
         ori_r   <= in_ori;
         walls_r <= in_walls;
         en_r    <= in_wall_en;
      end
      s1_idx   <= cnt;
      s1_en    <= en_r[cnt];
      s1_mag   <= mag_c;
      s1_sign  <= dir_r[DIR_W-1];
      s1_less  <= less_c;
      s1_delta <= delta_c;
      s1_recip <= inv_rom[mag_c];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_dist  <= '1;
         out_idx   <= '0;
         out_hit   <= 1'b0;
         s1_valid  <= 1'b0;
         best_dist <= '1;
         best_idx  <= '0;
         best_hit  <= 1'b0;
      end else begin
         s1_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state     <= SCAN;
                  in_ready  <= 1'b0;
                  cnt       <= '0;
                  best_dist <= '1;
                  best_idx  <= '0;
                  best_hit  <= 1'b0;
               end
            end
            SCAN: begin
               s1_valid <= 1'b1;
               if (cnt == LAST) state <= DRAIN;
               else             cnt   <= cnt + IDX_W'(1);
            end
            DRAIN: state <= DONE;
            DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_dist  <= best_dist;
                  out_idx   <= best_idx;
                  out_hit   <= best_hit;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Strict compare keeps the lower index on a tie; a hit always beats the all-ones miss code.
         if (s1_valid && !miss_c && (dist_c < best_dist)) begin
            best_dist <= dist_c;
            best_idx  <= s1_idx;
            best_hit  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ray_wall_scan.sv
// Bench for ray_wall_scan: directed corner cases plus random requests scored against an
// arithmetic model of the nearest-wall rule.
module tb_ray_wall_scan;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [9:0]  in_dir = '0;
   logic [9:0]  in_ori = '0;
   logic [15:0] in_walls = '0;
   logic [3:0]  in_wall_en = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [18:0] out_dist;
   logic [1:0]  out_idx;
   logic        out_hit;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ray_wall_scan dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_dir(in_dir), .in_ori(in_ori), .in_walls(in_walls), .in_wall_en(in_wall_en),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_dist(out_dist), .out_idx(out_idx), .out_hit(out_hit)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Nearest-wall rule in plain integer arithmetic.
   function automatic void model(input int dir, input int ori, input logic [15:0] walls,
                                 input logic [3:0] en, output int md, output int mi, output int mh);
      int mag, recip, wp, d;
      md = 524287; mi = 0; mh = 0;
      mag = (dir < 0) ? -dir : dir;
      if (mag > 511) mag = 511;
      recip = (mag < 2) ? 511 : (512 + mag / 2) / mag;
      for (int i = 0; i < 4; i++) begin
         wp = int'(walls[4*i +: 4]) * 64;
         if (!en[i] || dir == 0) continue;
         if (dir > 0 && wp < ori) continue;
         if (dir < 0 && wp >= ori) continue;
         d = (((ori > wp) ? ori - wp : wp - ori) * recip) / 2;
         if (d > 262143) d = 262143;
         if (d < md) begin
            md = d; mi = i; mh = 1;
         end
      end
   endfunction

   task automatic scramble();
      in_dir     = 10'($urandom);
      in_ori     = 10'($urandom);
      in_walls   = 16'($urandom);
      in_wall_en = 4'($urandom);
   endtask

   task automatic expect_result(input string tag, input int hold,
                                input int e_dist, input int e_idx, input int e_hit);
      int lat = 0;
      while (!out_valid && lat < 50) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, lat, 6);
      check({tag, "_dist"}, out_dist, e_dist);
      check({tag, "_idx"}, out_idx, e_idx);
      check({tag, "_hit"}, out_hit, e_hit);
      check({tag, "_rdy"}, in_ready, 0);
      for (int k = 0; k < hold; k++) begin
         tick();
         check({tag, "_hold_v"}, out_valid, 1);
         check({tag, "_hold_d"}, out_dist, e_dist);
         check({tag, "_hold_r"}, in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_drain_v"}, out_valid, 0);
      check({tag, "_drain_r"}, in_ready, 1);
   endtask

   task automatic run_req(input string tag, input int dir, input int ori, input logic [15:0] walls,
                          input logic [3:0] en, input int hold,
                          input int e_dist, input int e_idx, input int e_hit);
      int wait_cnt = 0;
      in_dir = 10'(dir); in_ori = 10'(ori); in_walls = walls; in_wall_en = en;
      in_valid = 1'b1;
      while (!in_ready && wait_cnt < 50) begin
         tick();
         wait_cnt++;
      end
      check({tag, "_accept"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      scramble();
      expect_result(tag, hold, e_dist, e_idx, e_hit);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int md, mi, mh, dir, ori, sel, seen;
      logic [15:0] walls;
      logic [3:0]  en;

      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_dist", out_dist, 524287);
      check("rst_idx", out_idx, 0);
      check("rst_hit", out_hit, 0);
      rst = 1'b0;
      tick();
      check("rst_ready", in_ready, 1);

      run_req("single", 256, 100, 16'h0002, 4'b0001, 0, 28, 0, 1);
      run_req("four", 256, 100, 16'h3210, 4'b1111, 0, 28, 2, 1);
      run_req("four_en", 256, 100, 16'h3210, 4'b1011, 0, 92, 3, 1);
      run_req("negdir", -256, 100, 16'h0001, 4'b0001, 0, 36, 0, 1);
      run_req("zerodir", 0, 100, 16'h3210, 4'b1111, 0, 524287, 0, 0);
      run_req("sat", 1, -512, 16'h000F, 4'b0001, 0, 262143, 0, 1);
      run_req("dir2", 2, -512, 16'h000F, 4'b0001, 0, 188416, 0, 1);
      run_req("edge", 256, 128, 16'h0002, 4'b0001, 0, 0, 0, 1);

      // in_valid stays high across the whole result: second request waits for the drain.
      in_dir = 10'(256); in_ori = 10'(100); in_walls = 16'h3210; in_wall_en = 4'b1111;
      in_valid = 1'b1;
      tick();
      in_walls = 16'h0022; in_wall_en = 4'b0011;
      expect_result("stall", 10, 28, 2, 1);
      tick();
      in_valid = 1'b0;
      scramble();
      expect_result("tie", 0, 28, 0, 1);

      // Reset two cycles into a scan.
      in_dir = 10'(256); in_ori = 10'(100); in_walls = 16'h3210; in_wall_en = 4'b1111;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #2;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_dist", out_dist, 524287);
      tick();
      rst = 1'b0;
      tick();
      check("mid_rst_ready", in_ready, 1);
      seen = 0;
      repeat (12) begin
         tick();
         if (out_valid) seen++;
      end
      check("mid_rst_noout", seen, 0);
      run_req("post_rst", 256, 100, 16'h3210, 4'b1111, 0, 28, 2, 1);

      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0:       dir = int'($urandom_range(0, 1023)) - 512;
            1:       dir = int'($urandom_range(0, 8)) - 4;
            2:       dir = ($urandom_range(0, 1) != 0) ? 256 : -256;
            default: dir = -512;
         endcase
         ori   = int'($urandom_range(0, 1023)) - 512;
         walls = 16'($urandom);
         en    = 4'($urandom);
         model(dir, ori, walls, en, md, mi, mh);
         run_req("rand", dir, ori, walls, en, $urandom_range(0, 3), md, mi, mh);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ray_wall_scan.md
RAY_WALL_SCAN -- requirements
Module: ray_wall_scan

Interface
REQ-001 SHALL provide parameter N_WALLS, default 4, number of wall positions scanned per request (1..16).
REQ-002 SHALL provide parameter WALL_W, default 4, unsigned wall index width.
REQ-003 SHALL provide parameter WALL_SHIFT, default 6, left shift converting wall index to position units.
REQ-004 SHALL provide parameter DIR_W, default 10, signed direction width, scaled 2^(DIR_W-2) (256 = 1.0 at default).
REQ-005 SHALL provide parameter ORI_W, default 10, signed origin width, scaled 2^0.
REQ-006 SHALL provide parameter DIST_W, default 19, distance output width.
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 in_valid  in  1  request present.
REQ-010 in_ready  out  1  block accepts a request.
REQ-011 in_dir  in  DIR_W  signed ray direction component.
REQ-012 in_ori  in  ORI_W  signed ray origin component.
REQ-013 in_walls  in  N_WALLS*WALL_W  wall indices; wall i at bits [i*WALL_W +: WALL_W].
REQ-014 in_wall_en  in  N_WALLS  per-wall enable; a disabled wall never hits.
REQ-015 out_valid  out  1  result present.
REQ-016 out_ready  in  1  consumer accepts result.
REQ-017 out_dist  out  DIST_W  nearest distance; all ones on miss.
REQ-018 out_idx  out  clog2(N_WALLS) (min 1)  index of nearest wall; 0 on miss.
REQ-019 out_hit  out  1  at least one wall hit.

Function
REQ-020 SHALL use an FSM with states IDLE, SCAN, DRAIN, DONE.
REQ-021 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready; on accept, capture in_dir, in_ori, in_walls, in_wall_en; clear the best-so-far register to miss; go to SCAN with counter i=0.
REQ-022 SCAN SHALL issue one wall per cycle, i=0..N_WALLS-1, into a 2-stage pipeline; after issuing wall N_WALLS-1 go to DRAIN for 1 cycle, then DONE.
REQ-023 out_valid SHALL rise exactly N_WALLS+2 cycles after the accept edge and stay high with stable outputs until out_valid & out_ready; then return to IDLE (no in_ready in that same cycle).
REQ-024 Stage 1 SHALL register: mag = |dir| (DIR_W-1 bits, saturating -2^(DIR_W-1) to max), wp = wall << WALL_SHIFT, less = (wp < ori, signed compare, wp zero-extended), delta = |ori - wp|, recip = INV[mag].
REQ-025 INV SHALL be a constant ROM of 2^(DIR_W-1) entries, DIR_W-1 bits: INV[0]=INV[1]=2^(DIR_W-1)-1, INV[k]=round(2^(DIR_W-1)/k) for k>=2 (default: INV[2]=256, INV[3]=171, INV[256]=2).
REQ-026 Stage 2 SHALL compute miss = (mag==0) | (dir_sign XOR less) | ~wall_en[i]; else dist = (delta*recip)>>1, saturated to 2^(DIST_W-1)-1 (MSB of a hit always 0).
REQ-027 Best update: non-miss candidate replaces best iff dist < best_dist strictly (equal distances keep lower index); best_hit set on first hit.
REQ-028 On miss for all walls: out_dist = all ones, out_idx = 0, out_hit = 0.
REQ-029 in_dir/in_ori/in_walls changes after accept SHALL NOT affect the running result.

Reset
REQ-030 rst high SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, out_dist=all ones, out_idx=0, out_hit=0, pipeline valids cleared; a scan interrupted by reset SHALL produce no output.

Verification
REQ-031 Single hit: N_WALLS=1, dir=+256, ori=100, wall=2, en=1 -> out_dist=28, out_idx=0, out_hit=1, out_valid 3 cycles after accept.
REQ-032 Nearest of four: dir=+256, ori=100, walls {0,1,2,3}, en=1111 -> walls 0,1 miss, 2->28, 3->92; out_dist=28, out_idx=2; repeat with en=1011 -> out_dist=92, out_idx=3.
REQ-033 Negative dir and zero dir: dir=-256, ori=100, wall=1 -> 36, hit; dir=0 -> out_dist=all ones, out_hit=0, out_idx=0.
REQ-034 Saturation: dir=+1, ori=-512, wall=15 -> (1472*511)>>1 exceeds range -> out_dist=262143, out_hit=1; dir=+2 same -> 188416.
REQ-035 Handshake: hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0; in_valid held throughout is accepted only after result drains; tie walls {2,2} -> out_idx=0.
REQ-036 Reset mid-SCAN: assert rst at cycle 2 after accept -> out_valid never asserted, in_ready=1 the cycle after release, next request gives correct result.
